bel_fft_twiddle_sequencer: RTL
==============================

Name: bel_fft_twiddle_sequencer

Overview:
- Sequences the multi-configuration twiddle ROM bank for a radix-2 DIT FFT.
- Generates the stage and butterfly twiddle address stream and drives the bank's address, read-enable and one-hot config select.
- Provides a valid/ready beat to the butterfly datapath, which consumes the ROM output word directly.
- Backpressure is handled by gating the ROM clock-enable, so the registered ROM output holds stable without an extra buffer.

Parameters:
- config_num, 1, number of ROM configurations (1..4).
- max_awidth, 6, ROM address bus width.
- log2_n, 7, log2 of FFT size for config 0 (ROM depth N/2).
- log2_n2, 7, same for config 1.
- log2_n3, 7, same for config 2.
- log2_n4, 7, same for config 3.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request to start a full FFT twiddle sequence.
- abort_i  in  1  synchronous abort.
- cfg_sel_i  in  config_num  one-hot configuration request, sampled at accepted start.
- adr_o  out  max_awidth  twiddle ROM address.
- rd_o  out  1  ROM read/clock-enable.
- cfg_sel_o  out  config_num  registered one-hot config select to the ROM bank.
- tw_valid_o  out  1  ROM output word valid.
- tw_ready_i  in  1  datapath accepts the current word.
- stage_o  out  3  stage index aligned with tw_valid_o.
- last_o  out  1  final word of the sequence, aligned with tw_valid_o.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (rst_i low, asynchronous): all outputs 0; cfg_sel_o = 1 (config 0); state IDLE; counters 0.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start_i.
  - Latch cfg_sel_i into cfg_sel_o.
  - A non-one-hot value (including zero or more than one bit set) selects config 0.
  - Set L = log2_n of the selected config.
  - Clear stage s and butterfly counter b.
- start_i outside IDLE is ignored.
- Address: adr_o = (b & (2^s - 1)) << (L-1-s), zero-extended to max_awidth. adr_o is combinational from the registered counters.
- rd_o = (state == RUN) & (!tw_valid_o | tw_ready_i).
- Counter advance on each rd_o:
  - b increments.
  - When b == 2^(L-1) - 1: b wraps to 0 and s increments.
  - When additionally s == L-1: go RUN -> DRAIN.
- Valid register: on rd_o, tw_valid_o <= 1 at the next edge and stage_o/last_o register the issued s and final-flag. Else if tw_ready_i, tw_valid_o <= 0. Else hold.
- Latency: start_i at edge T gives rd_o high from cycle T+1; first tw_valid_o at T+2. With ready held high: one word per cycle, no bubbles.
- Stall: tw_ready_i low with tw_valid_o high forces rd_o low. The ROM data, stage_o and last_o hold stable. Throughput resumes the cycle ready returns.
- DRAIN -> IDLE when the word with last_o is accepted (tw_valid_o & tw_ready_i & last_o). done_o pulses the following cycle.
- busy_o = state != IDLE.
- Total words per sequence = L * 2^(L-1).
- abort_i (any state):
  - Next edge: IDLE, tw_valid_o = 0, counters cleared, no done_o.
  - cfg_sel_o retains its value.
  - abort_i has priority over start_i in the same cycle.
- tw_ready_i while tw_valid_o is low has no effect.
- L values must satisfy L-1 <= max_awidth. The upper address bits stay 0 for smaller L.

Test Plan:
- config 0, L=7, ready tied 1, start pulse -> rd_o from T+1; 448 valid words.
  - Stage 0: 64× addr 0.
  - Stage 1: alternates 0,32.
  - Stage 6: 0..63.
  - last_o on word 448; done_o pulse one cycle later; busy_o low after.
- Random ready (~50% duty) -> address/stage sequence identical to ideal; ROM-output check shows no word dropped or duplicated; rd_o never high while valid & !ready.
- config_num=4, cfg_sel_i=4'b0100 with log2_n3=5 -> cfg_sel_o=0100; 80 words; stage 4 addresses 0..15; upper adr_o bits 0. Repeat with cfg_sel_i=4'b0110 -> config 0 selected.
- Start while busy at word 100 -> ignored; sequence completes unchanged with exactly one done_o.
- abort_i at word 200 with ready low -> next cycle tw_valid_o=0, busy_o=0, no done_o; a new start gives a correct full sequence.
- rst_i low mid-RUN -> outputs 0 immediately, asynchronously; after release, IDLE until start.

Source files
------------

// File: rtl/bel_fft_twiddle_sequencer.sv
// rtl/bel_fft_twiddle_sequencer.sv - twiddle ROM address sequencer for a radix-2 DIT FFT
module bel_fft_twiddle_sequencer #(
  parameter int config_num = 1,
  parameter int max_awidth = 6,
  parameter int log2_n     = 7,
  parameter int log2_n2    = 7,
  parameter int log2_n3    = 7,
  parameter int log2_n4    = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [config_num-1:0] cfg_sel_i,
  output logic [max_awidth-1:0] adr_o,
  output logic                  rd_o,
  output logic [config_num-1:0] cfg_sel_o,
  output logic                  tw_valid_o,
  input  logic                  tw_ready_i,
  output logic [2:0]            stage_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int AW1 = max_awidth + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              l_reg;
  logic [2:0]              s;
  logic [max_awidth-1:0]   b;
  logic [3:0]              sel_l;
  logic [config_num-1:0]   sel_cfg;
  logic                    sel_onehot;
  logic [AW1-1:0]          half;
  logic [AW1-1:0]          mask_w;
  logic                    b_wrap;
  logic                    s_last;
  logic                    final_word;
  logic                    accept;

  function automatic logic [3:0] cfg_len(input int idx);
    case (idx)
      0:       cfg_len = 4'(log2_n);
      1:       cfg_len = 4'(log2_n2);
      2:       cfg_len = 4'(log2_n3);
      default: cfg_len = 4'(log2_n4);
    endcase
  endfunction

  // Decode the requested config; anything that is not exactly one-hot falls back to config 0
  always_comb begin
    sel_onehot = (cfg_sel_i != '0) && ((cfg_sel_i & (cfg_sel_i - config_num'(1))) == '0);
    sel_cfg    = config_num'(1);
    sel_l      = cfg_len(0);
    if (sel_onehot) begin
      sel_cfg = cfg_sel_i;
      for (int i = 0; i < config_num; i++) begin
        if (cfg_sel_i[i]) sel_l = cfg_len(i);
      end
    end
  end

  // Butterfly/stage wrap detection and the per-stage address mask
  always_comb begin
    half       = AW1'(1) << (l_reg - 4'd1);
    mask_w     = (AW1'(1) << s) - AW1'(1);
    b_wrap     = ({1'b0, b} == (half - AW1'(1)));
    s_last     = ({1'b0, s} == (l_reg - 4'd1));
    final_word = b_wrap & s_last;
    accept     = tw_valid_o & tw_ready_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins over everything, including a same-cycle start
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nxt = RUN;
        RUN:     if (rd_o && final_word) state_nxt = DRAIN;
        DRAIN:   if (accept && last_o) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: ROM read is gated by backpressure so the registered ROM word holds while stalled
  always_comb begin
    busy_o = (state != IDLE);
    rd_o   = (state == RUN) & (~tw_valid_o | tw_ready_i);
    adr_o  = (b & mask_w[max_awidth-1:0]) << (l_reg - 4'd1 - {1'b0, s});
  end

  // Config latch and stage/butterfly counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg_sel_o <= config_num'(1);
      l_reg     <= '0;
      s         <= '0;
      b         <= '0;
    end else if (abort_i) begin
      s <= '0;
      b <= '0;
    end else if (state == IDLE && start_i) begin
      cfg_sel_o <= sel_cfg;
      l_reg     <= sel_l;
      s         <= '0;
      b         <= '0;
    end else if (rd_o) begin
      if (b_wrap) begin
        b <= '0;
        s <= final_word ? 3'd0 : s + 3'd1;
      end else begin
        b <= b + 1'b1;
      end
    end
  end

  // Valid/stage/last track the word the ROM is presenting after each read
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tw_valid_o <= 1'b0;
      stage_o    <= '0;
      last_o     <= 1'b0;
    end else if (abort_i) begin
      tw_valid_o <= 1'b0;
      stage_o    <= '0;
      last_o     <= 1'b0;
    end else if (rd_o) begin
      tw_valid_o <= 1'b1;
      stage_o    <= s;
      last_o     <= final_word;
    end else if (tw_ready_i) begin
      tw_valid_o <= 1'b0;
    end
  end

  // Completion pulse one cycle after the final word is taken
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) done_o <= 1'b0;
    else        done_o <= ~abort_i & (state == DRAIN) & accept & last_o;
  end

endmodule
